// File: rtl/transmission_estimator.sv
// ---------------------------------------------------------------------------
// transmission_estimator
//   Two-stage pipelined transmission-map stage for the dehazing datapath.
//   For every lane: t = max(1 - OMEGA*a, T0_MIN), all values unsigned
//   Q0.DATA_W, where a is the normalised dark-channel value.
//
//   Stage 1 : s = (OMEGA * a) >> DATA_W          (truncating)
//   Stage 2 : d = ONE - s ; t = (d <= T0_MIN) ? T0_MIN : d
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : input beat valid
//   in_ready   : block can accept an input beat (combinational from out_ready)
//   in_a       : LANES x DATA_W normalised dark values, lane k at [k*DATA_W +: DATA_W]
//   in_last    : last beat of frame
//   out_valid  : output beat valid
//   out_ready  : downstream accepts the beat
//   out_t      : LANES x DATA_W transmission values, same packing as in_a
//   out_last   : in_last travelling with its beat
//
// Optional feature (macro TRANS_CLAMP_STATS_EN)
//   clamp_count       : saturating count of clamped lanes over the last frame
//   clamp_count_valid : one-cycle pulse when clamp_count is updated
// ---------------------------------------------------------------------------
module transmission_estimator #(
   parameter int DATA_W = 16,
   parameter int LANES  = 1,
   parameter int OMEGA  = 62259,
   parameter int T0_MIN = 16384
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*DATA_W-1:0] in_a,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*DATA_W-1:0] out_t,
   output logic                    out_last
`ifdef TRANS_CLAMP_STATS_EN
   ,
   output logic [31:0]             clamp_count,
   output logic                    clamp_count_valid
`endif
);

   localparam logic [DATA_W-1:0] OMEGA_Q = DATA_W'(OMEGA);
   localparam logic [DATA_W-1:0] T0_Q    = DATA_W'(T0_MIN);
   localparam logic [DATA_W-1:0] ONE     = '1;

   logic                    s1_valid;
   logic                    s1_last;
   logic [LANES*DATA_W-1:0] s1_s;
   logic [LANES*DATA_W-1:0] s_next;
   logic [LANES*DATA_W-1:0] t_next;
   logic [LANES-1:0]        clamp_next;
   logic                    s1_load;
   logic                    s2_load;

   // Each stage loads when it is empty or its contents move on this edge,
   // so bubbles never block and in_ready only falls with both stages full.
   assign s2_load  = !out_valid || out_ready;
   assign s1_load  = !s1_valid || s2_load;
   assign in_ready = s1_load;

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [2*DATA_W-1:0] prod;
      logic [DATA_W-1:0]   d;

      assign prod = {{DATA_W{1'b0}}, OMEGA_Q} * {{DATA_W{1'b0}}, in_a[gi*DATA_W +: DATA_W]};
      assign s_next[gi*DATA_W +: DATA_W] = prod[2*DATA_W-1 -: DATA_W];

      // s <= ONE always, so the subtraction cannot wrap.
      assign d = ONE - s1_s[gi*DATA_W +: DATA_W];
      assign clamp_next[gi] = (d <= T0_Q);
      assign t_next[gi*DATA_W +: DATA_W] = clamp_next[gi] ? T0_Q : d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_last   <= 1'b0;
         s1_s      <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_t     <= '0;
      end else begin
         if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_s    <= s_next;
               s1_last <= in_last;
            end
         end
         if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               out_t    <= t_next;
               out_last <= s1_last;
            end
         end
      end
   end

`ifdef TRANS_CLAMP_STATS_EN
   logic [LANES-1:0] out_clamp;
   logic [31:0]      frame_count;
   logic [31:0]      beat_clamps;
   logic [32:0]      sum;
   logic [31:0]      total;

   always_comb begin
      beat_clamps = '0;
      for (int i = 0; i < LANES; i++) begin
         beat_clamps = beat_clamps + 32'(out_clamp[i]);
      end
      sum   = {1'b0, frame_count} + {1'b0, beat_clamps};
      total = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
   end

   // out_clamp travels with out_t so the count reflects the beat actually
   // transferred downstream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_clamp         <= '0;
         frame_count       <= '0;
         clamp_count       <= '0;
         clamp_count_valid <= 1'b0;
      end else begin
         clamp_count_valid <= 1'b0;
         if (s2_load && s1_valid) begin
            out_clamp <= clamp_next;
         end
         if (out_valid && out_ready) begin
            if (out_last) begin
               clamp_count       <= total;
               clamp_count_valid <= 1'b1;
               frame_count       <= '0;
            end else begin
               frame_count <= total;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_transmission_estimator.sv
// ---------------------------------------------------------------------------
// tb_transmission_estimator
//   Directed self-checking bench. Four instances share clk/rst_n:
//     dut_a : defaults, LANES=1          (basic, backpressure, mid-frame reset)
//     dut_b : OMEGA=65535, LANES=1       (clamp boundary)
//     dut_c : LANES=4                    (lane packing)
//     dut_d : LANES=2                    (frames, clamp statistics if enabled)
// ---------------------------------------------------------------------------
module tb_transmission_estimator;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   logic        a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_last;
   logic [15:0] a_in_a, a_out_t;
   logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_last;
   logic [15:0] b_in_a, b_out_t;
   logic        c_in_valid, c_in_ready, c_in_last, c_out_valid, c_out_ready, c_out_last;
   logic [63:0] c_in_a, c_out_t;
   logic        d_in_valid, d_in_ready, d_in_last, d_out_valid, d_out_ready, d_out_last;
   logic [31:0] d_in_a, d_out_t;
`ifdef TRANS_CLAMP_STATS_EN
   logic [31:0] d_clamp_count;
   logic        d_clamp_count_valid;
`endif

   transmission_estimator dut_a (
      .clk(clk), .rst_n(rst_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_a(a_in_a), .in_last(a_in_last),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_t(a_out_t), .out_last(a_out_last)
`ifdef TRANS_CLAMP_STATS_EN
      , .clamp_count(), .clamp_count_valid()
`endif
   );

   transmission_estimator #(.OMEGA(65535)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_a(b_in_a), .in_last(b_in_last),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_t(b_out_t), .out_last(b_out_last)
`ifdef TRANS_CLAMP_STATS_EN
      , .clamp_count(), .clamp_count_valid()
`endif
   );

   transmission_estimator #(.LANES(4)) dut_c (
      .clk(clk), .rst_n(rst_n),
      .in_valid(c_in_valid), .in_ready(c_in_ready), .in_a(c_in_a), .in_last(c_in_last),
      .out_valid(c_out_valid), .out_ready(c_out_ready), .out_t(c_out_t), .out_last(c_out_last)
`ifdef TRANS_CLAMP_STATS_EN
      , .clamp_count(), .clamp_count_valid()
`endif
   );

   transmission_estimator #(.LANES(2)) dut_d (
      .clk(clk), .rst_n(rst_n),
      .in_valid(d_in_valid), .in_ready(d_in_ready), .in_a(d_in_a), .in_last(d_in_last),
      .out_valid(d_out_valid), .out_ready(d_out_ready), .out_t(d_out_t), .out_last(d_out_last)
`ifdef TRANS_CLAMP_STATS_EN
      , .clamp_count(d_clamp_count), .clamp_count_valid(d_clamp_count_valid)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      a_in_valid = 0; a_in_last = 0; a_in_a = '0; a_out_ready = 1;
      b_in_valid = 0; b_in_last = 0; b_in_a = '0; b_out_ready = 1;
      c_in_valid = 0; c_in_last = 0; c_in_a = '0; c_out_ready = 1;
      d_in_valid = 0; d_in_last = 0; d_in_a = '0; d_out_ready = 1;
      #3;
      checks++;
      if (a_out_valid !== 1'b0 || a_out_t !== 16'd0 || a_out_last !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b t=%0d last=%b, expected 0 0 0", a_out_valid, a_out_t, a_out_last);
      end
      checks++;
      if (a_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b expected 1", a_in_ready);
      end
      checks++;
      if (c_out_valid !== 1'b0 || c_out_t !== 64'd0) begin
         errors++;
         $display("FAIL reset_lanes4: got valid=%b t=%h expected 0 0", c_out_valid, c_out_t);
      end
      step();
      rst_n = 1'b1;
      step();
      $display("txn reset: done");
   endtask

   task automatic test_basic();
      logic [15:0] vals [3] = '{16'd0, 16'd32768, 16'd65535};
      logic [15:0] exp_t [3] = '{16'd65535, 16'd34406, 16'd16384};
      a_out_ready = 1;
      for (int i = 0; i < 5; i++) begin
         a_in_valid = (i < 3);
         a_in_a     = (i < 3) ? vals[i] : 16'd0;
         step();
         checks++;
         if (i == 0 || i == 4) begin
            if (a_out_valid !== 1'b0) begin
               errors++;
               $display("FAIL basic_latency_%0d: got out_valid=%b expected 0", i, a_out_valid);
            end
         end else if (a_out_valid !== 1'b1 || a_out_t !== exp_t[i-1]) begin
            errors++;
            $display("FAIL basic_beat_%0d: got valid=%b t=%0d expected 1 %0d", i-1, a_out_valid, a_out_t, exp_t[i-1]);
         end else begin
            $display("txn basic: beat %0d out_t=%0d", i-1, a_out_t);
         end
      end
   endtask

   task automatic test_omega_boundary();
      logic [15:0] vals [3] = '{16'd49151, 16'd49152, 16'd49153};
      logic [15:0] exp_t [3] = '{16'd16385, 16'd16384, 16'd16384};
      b_out_ready = 1;
      for (int i = 0; i < 5; i++) begin
         b_in_valid = (i < 3);
         b_in_a     = (i < 3) ? vals[i] : 16'd0;
         step();
         if (i >= 1 && i <= 3) begin
            checks++;
            if (b_out_valid !== 1'b1 || b_out_t !== exp_t[i-1]) begin
               errors++;
               $display("FAIL omega_beat_%0d: got valid=%b t=%0d expected 1 %0d", i-1, b_out_valid, b_out_t, exp_t[i-1]);
            end else begin
               $display("txn omega: beat %0d out_t=%0d", i-1, b_out_t);
            end
         end
      end
   endtask

   task automatic test_lanes();
      c_out_ready = 1;
      c_in_valid  = 1;
      c_in_a      = {16'd0, 16'd32768, 16'd65535, 16'd0};
      step();
      c_in_valid = 0;
      step();
      checks++;
      if (c_out_valid !== 1'b1 || c_out_t !== {16'd65535, 16'd34406, 16'd16384, 16'd65535}) begin
         errors++;
         $display("FAIL lanes4: got valid=%b t=%h expected 1 %h", c_out_valid, c_out_t,
                  {16'd65535, 16'd34406, 16'd16384, 16'd65535});
      end else begin
         $display("txn lanes4: out_t=%h", c_out_t);
      end
      step();
   endtask

   task automatic test_backpressure();
      int          sent = 0;
      int          recv = 0;
      int          inflight;
      logic [15:0] exp_t [8] = '{16'd65535, 16'd61644, 16'd57753, 16'd53862,
                                 16'd49971, 16'd46080, 16'd42188, 16'd38297};
      logic        prev_stall = 1'b0;
      logic [15:0] prev_t = '0;
      logic        exp_ready;
      logic        s_in_ready, s_out_valid, s_out_last;
      logic [15:0] s_out_t;
      for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
         a_out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         a_in_valid  = (sent < 8);
         a_in_a      = 16'(sent * 4096);
         a_in_last   = (sent == 7);
         #1;
         inflight  = sent - recv;
         exp_ready = !(inflight == 2 && !a_out_ready);
         checks++;
         if (a_in_ready !== exp_ready) begin
            errors++;
            $display("FAIL bp_in_ready_c%0d: got %b expected %b", cyc, a_in_ready, exp_ready);
         end
         if (prev_stall) begin
            checks++;
            if (a_out_valid !== 1'b1 || a_out_t !== prev_t) begin
               errors++;
               $display("FAIL bp_stall_hold_c%0d: got valid=%b t=%0d expected 1 %0d", cyc, a_out_valid, a_out_t, prev_t);
            end
         end
         s_in_ready  = a_in_ready;
         s_out_valid = a_out_valid;
         s_out_t     = a_out_t;
         s_out_last  = a_out_last;
         step();
         if (a_in_valid && s_in_ready) sent++;
         if (s_out_valid && a_out_ready) begin
            checks++;
            if (s_out_t !== exp_t[recv] || s_out_last !== (recv == 7)) begin
               errors++;
               $display("FAIL bp_beat_%0d: got t=%0d last=%b expected %0d %b", recv, s_out_t, s_out_last, exp_t[recv], recv == 7);
            end else begin
               $display("txn bp: beat %0d out_t=%0d last=%b", recv, s_out_t, s_out_last);
            end
            recv++;
         end
         prev_stall = s_out_valid && !a_out_ready;
         prev_t     = s_out_t;
      end
      checks++;
      if (sent != 8 || recv != 8) begin
         errors++;
         $display("FAIL bp_count: got sent=%0d recv=%0d expected 8 8", sent, recv);
      end
      a_in_valid = 0; a_in_last = 0; a_out_ready = 1;
      step();
      checks++;
      if (a_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_no_dup: got out_valid=%b expected 0", a_out_valid);
      end
   endtask

   task automatic test_reset_midframe();
      a_out_ready = 0;
      a_in_valid  = 1;
      a_in_last   = 1;
      a_in_a      = 16'd0;
      step();
      a_in_a = 16'd65535;
      step();
      a_in_valid = 0;
      #1;
      checks++;
      if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1) begin
         errors++;
         $display("FAIL rst_full: got in_ready=%b out_valid=%b expected 0 1", a_in_ready, a_out_valid);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (a_out_valid !== 1'b0 || a_out_last !== 1'b0 || a_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_async: got valid=%b last=%b in_ready=%b expected 0 0 1", a_out_valid, a_out_last, a_in_ready);
      end
      step();
      rst_n       = 1'b1;
      a_out_ready = 1;
      a_in_valid  = 1;
      a_in_last   = 0;
      a_in_a      = 16'd32768;
      step();
      a_in_valid = 0;
      checks++;
      if (a_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_resume_latency: got out_valid=%b expected 0", a_out_valid);
      end
      step();
      checks++;
      if (a_out_valid !== 1'b1 || a_out_t !== 16'd34406 || a_out_last !== 1'b0) begin
         errors++;
         $display("FAIL rst_resume_beat: got valid=%b t=%0d last=%b expected 1 34406 0", a_out_valid, a_out_t, a_out_last);
      end else begin
         $display("txn rst: resumed out_t=%0d", a_out_t);
      end
      step();
      checks++;
      if (a_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_no_stale: got out_valid=%b expected 0", a_out_valid);
      end
   endtask

   task automatic test_stats();
      // Lane 1 in the upper half. Clamped lanes per beat: 1, 2, 0 | 1.
      logic [31:0] vals [4]  = '{{16'd65535, 16'd0}, {16'd65535, 16'd65535},
                                 {16'd0, 16'd0},     {16'd0, 16'd65535}};
      logic [31:0] exp_t [4] = '{{16'd16384, 16'd65535}, {16'd16384, 16'd16384},
                                 {16'd65535, 16'd65535}, {16'd65535, 16'd16384}};
      logic        lasts [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      d_out_ready = 1;
      for (int i = 0; i < 8; i++) begin
         d_in_valid = (i < 4);
         d_in_a     = (i < 4) ? vals[i] : 32'd0;
         d_in_last  = (i < 4) ? lasts[i] : 1'b0;
         step();
         if (i >= 1 && i <= 4) begin
            checks++;
            if (d_out_valid !== 1'b1 || d_out_t !== exp_t[i-1] || d_out_last !== lasts[i-1]) begin
               errors++;
               $display("FAIL stats_beat_%0d: got valid=%b t=%h last=%b expected 1 %h %b",
                        i-1, d_out_valid, d_out_t, d_out_last, exp_t[i-1], lasts[i-1]);
            end else begin
               $display("txn stats: beat %0d out_t=%h last=%b", i-1, d_out_t, d_out_last);
            end
         end
`ifdef TRANS_CLAMP_STATS_EN
         checks++;
         if (i == 4) begin
            if (d_clamp_count_valid !== 1'b1 || d_clamp_count !== 32'd3) begin
               errors++;
               $display("FAIL stats_frame1: got valid=%b count=%0d expected 1 3", d_clamp_count_valid, d_clamp_count);
            end
         end else if (i == 5) begin
            if (d_clamp_count_valid !== 1'b1 || d_clamp_count !== 32'd1) begin
               errors++;
               $display("FAIL stats_frame2: got valid=%b count=%0d expected 1 1", d_clamp_count_valid, d_clamp_count);
            end
         end else if (d_clamp_count_valid !== 1'b0) begin
            errors++;
            $display("FAIL stats_pulse_c%0d: got clamp_count_valid=%b expected 0", i, d_clamp_count_valid);
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_omega_boundary();
      test_lanes();
      test_backpressure();
      test_reset_midframe();
      test_stats();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
